// File: rtl/dm_subword.sv
// dm_subword: word-organised data memory with byte/half/word access.
// Registered load path, merged sub-word stores, alignment checking.
module dm_subword #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [31:0]      word;
  logic [31:0]      merged;
  logic [31:0]      ld_res;
  logic [31:0]      wd;
  logic [3:0]       be;
  logic [7:0]       bsel;
  logic [15:0]      hsel;
  logic             is_b, is_h, is_w;
  logic             illegal;
  logic             st, ld;
  logic             rvalid_q, err_q;
  logic             unused_bits;

  assign idx  = req_addr[IDX_W+1:2];
  assign off  = req_addr[1:0];
  assign word = mem[idx];
  assign bsel = word[{off, 3'b000} +: 8];
  assign hsel = off[1] ? word[31:16] : word[15:0];
  assign is_b = (req_size == 2'd0);
  assign is_h = (req_size == 2'd1);
  assign is_w = (req_size == 2'd2);

  assign unused_bits = ^{req_addr[31:IDX_W+2], pc};

  // Size decode: lane enables, replicated store data, extended load data.
  always_comb begin
    be      = 4'b0000;
    wd      = 32'h0;
    ld_res  = 32'h0;
    illegal = 1'b1;
    unique case (1'b1)
      is_b: begin
        illegal = 1'b0;
        be      = 4'b0001 << off;
        wd      = {4{req_wdata[7:0]}};
        ld_res  = {{24{req_sign & bsel[7]}}, bsel};
      end
      is_h: begin
        illegal = off[0];
        be      = off[1] ? 4'b1100 : 4'b0011;
        wd      = {2{req_wdata[15:0]}};
        ld_res  = {{16{req_sign & hsel[15]}}, hsel};
      end
      is_w: begin
        illegal = |off;
        be      = 4'b1111;
        wd      = req_wdata;
        ld_res  = word;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Byte-lane merge of store data into the current word.
  always_comb begin
    merged = word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
    end
  end

  assign st = req_valid & ~illegal & req_we;
  assign ld = req_valid & ~illegal & ~req_we;

  // Memory array: cleared on reset, written on legal stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (st) begin
      mem[idx] <= merged;
    end
  end

  // Response registers; rdata holds between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= ld;
      err_q    <= req_valid & illegal;
      if (ld) rdata <= ld_res;
    end
  end

  // A response from the cycle before reset is suppressed during reset.
  assign rvalid = rvalid_q & ~reset;
  assign err    = err_q & ~reset;

`ifndef SYNTHESIS
  // Store trace: pc, word-aligned address, merged word.
  always_ff @(posedge clk) begin
    if (!reset && st)
      $display("@%08h: *%08h <= %08h",
               pc, {req_addr[31:2], 2'b00}, merged);
  end
`endif

endmodule
